// File: rtl/move_commit_ctrl.sv
// move_commit_ctrl: chess turn sequencer owning the board, selection, move validation and commit
//   in : clk, rst_n (async active-low), click_valid/click_pos (square click),
//        new_game (restart), possible_moves (64-bit mask from move generator)
//   out: sel_figure/sel_pos/sel_valid (selection to move generator), highlight (registered mask),
//        board_flat (4 bits per square), turn, move_done/illegal_move (pulses), game_over (sticky)
module move_commit_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         click_valid,
  input  logic [5:0]   click_pos,
  input  logic         new_game,
  input  logic [63:0]  possible_moves,
  output logic [3:0]   sel_figure,
  output logic [5:0]   sel_pos,
  output logic         sel_valid,
  output logic [63:0]  highlight,
  output logic [255:0] board_flat,
  output logic         turn,
  output logic         move_done,
  output logic         illegal_move,
  output logic         game_over
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_TARGET, COMMIT, OVER} state_t;
  // rows 7..0, each row packs col 7 in the top nibble down to col 0
  localparam logic [255:0] START =
    256'hABCEDCBA_99999999_00000000_00000000_00000000_00000000_11111111_23465432;
  state_t         state_q, state_d;
  logic [255:0]   board_q, board_d;
  logic [63:0]    highlight_q, highlight_d;
  logic [5:0]     sel_pos_q, sel_pos_d, tgt_q, tgt_d;
  logic [3:0]     sel_figure_q, sel_figure_d;
  logic           sel_valid_q, sel_valid_d, turn_q, turn_d;
  logic           move_done_q, move_done_d, illegal_q, illegal_d, game_over_q, game_over_d;
  logic [3:0]     click_sq, tgt_sq, fig_w;
  logic           click_own, promote;
  assign click_sq  = board_q[{click_pos, 2'b00} +: 4];
  assign tgt_sq    = board_q[{tgt_q, 2'b00} +: 4];
  assign click_own = click_sq != 4'd0 && click_sq[3] == turn_q;
  // a pawn landing on the far row for its colour becomes a queen
  assign promote   = sel_figure_q[2:0] == 3'd1 &&
                     (sel_figure_q[3] ? tgt_q[5:3] == 3'd0 : tgt_q[5:3] == 3'd7);
  assign fig_w     = promote ? {sel_figure_q[3], 3'd5} : sel_figure_q;
  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    highlight_d  = highlight_q;
    sel_pos_d    = sel_pos_q;
    sel_figure_d = sel_figure_q;
    sel_valid_d  = sel_valid_q;
    tgt_d        = tgt_q;
    turn_d       = turn_q;
    game_over_d  = game_over_q;
    move_done_d  = 1'b0;
    illegal_d    = 1'b0;
    if (new_game) begin
      state_d     = IDLE;
      board_d     = START;
      turn_d      = 1'b0;
      game_over_d = 1'b0;
      sel_valid_d = 1'b0;
      highlight_d = '0;
    end else begin
      case (state_q)
        IDLE: if (click_valid) begin
          if (click_own) begin
            sel_pos_d    = click_pos;
            sel_figure_d = click_sq;
            sel_valid_d  = 1'b1;
            state_d      = LOOKUP;
          end else illegal_d = 1'b1;
        end
        LOOKUP: begin
          highlight_d = possible_moves;
          state_d     = WAIT_TARGET;
        end
        WAIT_TARGET: if (click_valid) begin
          if (click_pos == sel_pos_q) begin
            sel_valid_d = 1'b0;
            highlight_d = '0;
            state_d     = IDLE;
          end else if (click_own) begin
            sel_pos_d    = click_pos;
            sel_figure_d = click_sq;
            state_d      = LOOKUP;
          end else if (highlight_q[click_pos]) begin
            tgt_d   = click_pos;
            state_d = COMMIT;
          end else illegal_d = 1'b1;
        end
        COMMIT: begin
          board_d[{tgt_q, 2'b00} +: 4]     = fig_w;
          board_d[{sel_pos_q, 2'b00} +: 4] = 4'd0;
          move_done_d = 1'b1;
          sel_valid_d = 1'b0;
          highlight_d = '0;
          game_over_d = tgt_sq[2:0] == 3'd6;
          turn_d      = tgt_sq[2:0] == 3'd6 ? turn_q : ~turn_q;
          state_d     = tgt_sq[2:0] == 3'd6 ? OVER : IDLE;
        end
        OVER: state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      board_q      <= START;
      highlight_q  <= '0;
      sel_pos_q    <= '0;
      sel_figure_q <= '0;
      sel_valid_q  <= 1'b0;
      tgt_q        <= '0;
      turn_q       <= 1'b0;
      game_over_q  <= 1'b0;
      move_done_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      highlight_q  <= highlight_d;
      sel_pos_q    <= sel_pos_d;
      sel_figure_q <= sel_figure_d;
      sel_valid_q  <= sel_valid_d;
      tgt_q        <= tgt_d;
      turn_q       <= turn_d;
      game_over_q  <= game_over_d;
      move_done_q  <= move_done_d;
      illegal_q    <= illegal_d;
    end
  end
  assign sel_figure   = sel_figure_q;
  assign sel_pos      = sel_pos_q;
  assign sel_valid    = sel_valid_q;
  assign highlight    = highlight_q;
  assign board_flat   = board_q;
  assign turn         = turn_q;
  assign move_done    = move_done_q;
  assign illegal_move = illegal_q;
  assign game_over    = game_over_q;
endmodule

// File: doc/move_commit_ctrl.md
# move_commit_ctrl

Turn-sequencing controller that owns the chess board state. It accepts square clicks from the cursor/input path and drives the selected figure code and position into the combinational move generator. It registers the returned `possible_moves` mask, validates the player's target click against it and commits the move into the board register. It sits between the mouse/cursor logic and the move generator; its `board_flat` output feeds both the move generator and the display path.

## Interface
Parameters:
- none (8x8 board, 4-bit square codes fixed)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `click_valid`  in  1  one-cycle pulse: player clicked a square
- `click_pos`  in  6  clicked square, [2:0] column, [5:3] row
- `new_game`  in  1  one-cycle pulse: reload start position
- `possible_moves`  in  64  mask from move generator, bit r*8+c
- `sel_figure`  out  4  code of selected figure to move generator
- `sel_pos`  out  6  position of selected figure
- `sel_valid`  out  1  a source square is currently selected
- `highlight`  out  64  registered move mask for display; 0 when nothing selected
- `board_flat`  out  256  square i = r*8+c at bits [4i+3:4i]
- `turn`  out  1  0 = white to move, 1 = black
- `move_done`  out  1  one-cycle pulse after a move is committed
- `illegal_move`  out  1  one-cycle pulse on rejected click
- `game_over`  out  1  sticky: a king was captured

## Operation
- Square code: [2:0] type (0 empty, 1 pawn, 2 rook, 3 knight, 4 bishop, 5 queen, 6 king); [3] colour (0 white, 1 black). Empty square is always 4'b0000.
- Start position:
  - row 0: 2,3,4,5,6,4,3,2 (col 0..7)
  - row 1: all 1
  - rows 2-5: 0
  - row 6: all 9
  - row 7: 10,11,12,13,14,12,11,10
- FSM states: IDLE, LOOKUP, WAIT_TARGET, COMMIT, OVER.
- IDLE, on `click_valid`:
  - If the square is non-empty and its colour equals `turn`: latch `sel_pos`/`sel_figure`, set `sel_valid`, go to LOOKUP.
  - Otherwise pulse `illegal_move` and stay in IDLE.
- LOOKUP: lasts exactly 1 cycle. At its end, `possible_moves` is registered into `highlight`, then go to WAIT_TARGET.
- WAIT_TARGET, on `click_valid`:
  - `click_pos == sel_pos`: deselect, clear `sel_valid` and `highlight`, go to IDLE. No pulse.
  - Clicked square holds own-colour piece: reselect that piece, go to LOOKUP. No pulse.
  - `highlight[click_pos]` = 1: latch target, go to COMMIT.
  - Otherwise: pulse `illegal_move`, stay in WAIT_TARGET.
- COMMIT: lasts exactly 1 cycle.
  - Target square gets `sel_figure`, source square gets 0.
  - Pawn reaching the far row (white row 7, black row 0) is written as queen of its colour.
  - If the target held a king (type 6), set `game_over` and go to OVER. Otherwise toggle `turn` and go to IDLE.
  - In all cases: pulse `move_done`, clear `sel_valid` and `highlight`.
- OVER: all clicks are ignored. Only `new_game` leaves this state.
- `new_game` in any state, same cycle as a click or not:
  - reload start position, `turn`=0, clear `game_over`/`sel_valid`/`highlight`, go to IDLE; the click is dropped.
- Clicks arriving during LOOKUP or COMMIT are ignored with no pulse.

## Timing
- All outputs are registered.
- Reset values:
  - board = start position; `turn`=0
  - `sel_figure`=0, `sel_pos`=0, `sel_valid`=0, `highlight`=0
  - `move_done`=0, `illegal_move`=0, `game_over`=0
  - state IDLE
- Source click at edge N: `sel_pos`/`sel_figure`/`sel_valid` are valid after edge N.
- The move generator is combinational and must settle within one cycle. `possible_moves` is sampled at edge N+1 and `highlight` is valid after edge N+1.
- Earliest accepted target click is sampled at edge N+2.
- Target click at edge T: COMMIT occupies cycle T..T+1.
  - Board, `turn` and `game_over` update after edge T+1.
  - `move_done` is high for exactly the cycle after edge T+1.
- `illegal_move` is high for exactly the one cycle following the rejected click edge.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous). Release is synchronous to `clk`.

## Test plan
- Reset: release `rst_n` -> `board_flat` square 4 = 6, square 60 = 14, square 12 = 1, square 52 = 9; `turn`=0; all pulse outputs 0.
- White pawn move: click 12, mask with bits 20 and 28 set, click 28 -> `move_done` pulse, square 28 = 1, square 12 = 0, `turn`=1, `highlight`=0.
- Illegal target: select 12, click 36 (mask bit 0) -> one `illegal_move` pulse, state stays WAIT_TARGET, board unchanged. Then click 12 -> `sel_valid`=0.
- Wrong colour / empty source: with `turn`=0, click 52, then click 30 -> two `illegal_move` pulses, `sel_valid` stays 0.
- King capture: preload a position via a move sequence with the mask forcing the target bit on the square holding 14 -> `game_over`=1, `turn` unchanged, subsequent clicks ignored. `new_game` -> start position, `game_over`=0.
- Promotion and abort: white pawn committed to row 7 -> target square = 5. Separately, `new_game` asserted together with `click_valid` while in WAIT_TARGET -> click dropped, start position restored, state IDLE.
